// File: rtl/condicionador_botoes.sv
// Debounces 7 game buttons plus start: 2-FF sync, per-input counter, rising-edge pulses and play decode.
// Optional CONDICIONADOR_BLOQUEIO_EN: lock tem_jogada/multipla after a play until all buttons are released.
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] botoes_raw,
  input  logic       iniciar_raw,
  output logic [6:0] botoes,
  output logic [6:0] botoes_pulso,
  output logic       iniciar_pulso,
  output logic       tem_jogada,
  output logic [2:0] codigo,
  output logic       multipla
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    raw_all;
  logic [7:0]    sync1, sync2, nivel;
  logic [CW-1:0] cnt [8];
  logic [7:0]    aceita, sobe;
  logic [3:0]    qtd;
  logic [2:0]    idx;
  logic          um, varios;
  logic          bloqueado;

  // Bit 7 is the start button; it shares the debouncer but not the play decode.
  assign raw_all = {iniciar_raw, botoes_raw};

  always_comb begin
    aceita = '0;
    sobe   = '0;
    for (int i = 0; i < 8; i++) begin
      aceita[i] = (sync2[i] != nivel[i]) && (cnt[i] == CNT_MAX);
      sobe[i]   = aceita[i] && sync2[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      nivel <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == nivel[i]) begin
          cnt[i] <= '0;
        end else if (aceita[i]) begin
          nivel[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    qtd = '0;
    idx = '0;
    for (int i = 0; i < 7; i++) begin
      qtd = qtd + 4'(sobe[i]);
      if (sobe[i]) idx = 3'(i);
    end
    um     = (qtd == 4'd1);
    varios = (qtd > 4'd1);
  end

`ifdef CONDICIONADOR_BLOQUEIO_EN
  logic trava;

  // Setting wins: a play cycle can never coincide with all buttons released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        trava <= 1'b0;
    else if (tem_jogada || multipla)  trava <= 1'b1;
    else if (botoes == 7'd0)          trava <= 1'b0;
  end

  assign bloqueado = trava;
`else
  assign bloqueado = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botoes_pulso  <= '0;
      iniciar_pulso <= 1'b0;
      tem_jogada    <= 1'b0;
      codigo        <= '0;
      multipla      <= 1'b0;
    end else begin
      botoes_pulso  <= sobe[6:0];
      iniciar_pulso <= sobe[7];
      tem_jogada    <= um && !bloqueado;
      codigo        <= (um && !bloqueado) ? idx : 3'd0;
      multipla      <= varios && !bloqueado;
    end
  end

  assign botoes = nivel[6:0];

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes with DEBOUNCE_CYCLES=4; stimulus pushes expected pulses, monitor pops.
module tb_condicionador_botoes;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] botoes_raw;
  logic       iniciar_raw;
  logic [6:0] botoes, botoes_pulso;
  logic       iniciar_pulso, tem_jogada, multipla;
  logic [2:0] codigo;

  typedef struct {
    logic [6:0] pulso;
    logic       tj;
    logic [2:0] cod;
    logic       mul;
    logic       ini;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edges = 0;

  condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .botoes_raw(botoes_raw), .iniciar_raw(iniciar_raw),
    .botoes(botoes), .botoes_pulso(botoes_pulso), .iniciar_pulso(iniciar_pulso),
    .tem_jogada(tem_jogada), .codigo(codigo), .multipla(multipla)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  task automatic push(input logic [6:0] p, input logic tj, input logic [2:0] c,
                      input logic mul, input logic ini, input int at);
    exp_t e;
    e.pulso = p; e.tj = tj; e.cod = c; e.mul = mul; e.ini = ini; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_edges(input int target);
    while (edges < target) @(negedge clock);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_botoes"}, 32'(botoes), 0);
    chk({nm, "_pulso"}, 32'(botoes_pulso), 0);
    chk({nm, "_ini"}, 32'(iniciar_pulso), 0);
    chk({nm, "_tj"}, 32'(tem_jogada), 0);
    chk({nm, "_cod"}, 32'(codigo), 0);
    chk({nm, "_mul"}, 32'(multipla), 0);
  endtask

  // Monitor: any active pulse output is a transaction to be matched against the scoreboard.
  always @(negedge clock) begin
    if (!reset && ((|botoes_pulso) || iniciar_pulso || tem_jogada || multipla || (|codigo))) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {botoes_pulso, iniciar_pulso, tem_jogada, multipla, codigo}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulso", 32'(botoes_pulso), 32'(e.pulso));
        chk("tem_jogada", 32'(tem_jogada), 32'(e.tj));
        chk("codigo", 32'(codigo), 32'(e.cod));
        chk("multipla", 32'(multipla), 32'(e.mul));
        chk("iniciar_pulso", 32'(iniciar_pulso), 32'(e.ini));
        chk("pulse_edge", edges, e.at);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    botoes_raw = '0;
    iniciar_raw = 1'b0;
    repeat (3) @(negedge clock);
    chk_zero_outputs("reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single press of button 2
    n = edges;
    botoes_raw = 7'b0000100;
    push(7'b0000100, 1'b1, 3'd2, 1'b0, 1'b0, n + 2 + D);
    wait_edges(n + 1 + D);
    chk("b2_before", 32'(botoes), 0);
    @(negedge clock);
    chk("b2_after", 32'(botoes), 32'(7'b0000100));
    botoes_raw = '0;
    repeat (12) @(negedge clock);
    chk("b2_released", 32'(botoes), 0);

    // Glitch shorter than the debounce window
    botoes_raw = 7'b0000001;
    repeat (2) @(negedge clock);
    botoes_raw = '0;
    for (int i = 0; i < 10; i++) begin
      chk("glitch_botoes", 32'(botoes), 0);
      @(negedge clock);
    end

    // Two buttons in the same cycle
    n = edges;
    botoes_raw = 7'b0100001;
    push(7'b0100001, 1'b0, 3'd0, 1'b1, 1'b0, n + 2 + D);
    repeat (10) @(negedge clock);
    chk("multi_level", 32'(botoes), 32'(7'b0100001));
    botoes_raw = '0;
    repeat (12) @(negedge clock);

    // Hold button 1, then add button 3
    n = edges;
    botoes_raw = 7'b0000010;
    push(7'b0000010, 1'b1, 3'd1, 1'b0, 1'b0, n + 2 + D);
    repeat (10) @(negedge clock);
    n = edges;
    botoes_raw = 7'b0001010;
`ifdef CONDICIONADOR_BLOQUEIO_EN
    push(7'b0001000, 1'b0, 3'd0, 1'b0, 1'b0, n + 2 + D);
`else
    push(7'b0001000, 1'b1, 3'd3, 1'b0, 1'b0, n + 2 + D);
`endif
    repeat (10) @(negedge clock);
    chk("hold_level", 32'(botoes), 32'(7'b0001010));
    botoes_raw = '0;
    repeat (12) @(negedge clock);

    // Reset in the middle of a count, button 6 held through it
    n = edges;
    botoes_raw = 7'b1000000;
    wait_edges(n + 4);
    reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = edges;
    push(7'b1000000, 1'b1, 3'd6, 1'b0, 1'b0, n + 2 + D);
    wait_edges(n + 1 + D);
    chk("b6_before", 32'(botoes), 0);
    @(negedge clock);
    chk("b6_after", 32'(botoes), 32'(7'b1000000));
    botoes_raw = '0;
    repeat (12) @(negedge clock);

    // Start button held
    n = edges;
    iniciar_raw = 1'b1;
    push(7'b0000000, 1'b0, 3'd0, 1'b0, 1'b1, n + 2 + D);
    repeat (15) @(negedge clock);
    iniciar_raw = 1'b0;
    repeat (12) @(negedge clock);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
